// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types for the RV32I instruction-fetch stage.
// Revision: 1.0
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf -- one-entry holding buffer for a fetched instruction.
// Revision: 1.0
`default_nettype none

module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  load_i,
  input  logic  pop_i,
  input  logic  clear_i,
  input  ifid_t data_i,
  output logic  full_o,
  output ifid_t data_o
);

  logic  full_q;
  ifid_t data_q;

  // Clear wins over load so a redirect always discards the captured response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/fetch_cycle.sv
// fetch_cycle -- IF stage: PC, single-outstanding imem handshake, IF/ID register.
// Revision: 1.0
`default_nettype none

module fetch_cycle
  import fetch_pkg::fetch_state_t, fetch_pkg::ifid_t,
         fetch_pkg::F_REQ, fetch_pkg::F_WAIT, fetch_pkg::F_DROP;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = fetch_pkg::NOP_INSN
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallF,
  input  logic        i_stallD,
  input  logic        i_flushD,
  input  logic        i_pc_selE,
  input  logic [31:0] i_pc_targetE,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_InstrD,
  output logic [31:0] o_PCD,
  output logic [31:0] o_PCPlus4D,
  output logic        o_validD
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_inflight_q;
  ifid_t        ifid_q;

  logic  req;
  logic  accepted;
  logic  deliver;
  logic  skid_full;
  logic  skid_load;
  logic  skid_pop;
  ifid_t resp;
  ifid_t skid_data;

  assign req      = (state_q == F_REQ) & ~i_stallF & ~skid_full & i_rst_n;
  assign accepted = req & i_imem_gnt;
  assign deliver  = (state_q == F_WAIT) & i_imem_rvalid & ~i_pc_selE;
  assign resp     = {i_imem_rdata, pc_inflight_q, pc_inflight_q + 32'd4, 1'b1};

  assign skid_load = deliver & (i_flushD | i_stallD);
  assign skid_pop  = skid_full & ~i_flushD & ~i_stallD & ~i_pc_selE;

  fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .clear_i (i_pc_selE),
    .data_i  (resp),
    .full_o  (skid_full),
    .data_o  (skid_data)
  );

  // A redirect updates the PC regardless of stallF or the handshake state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= F_REQ;
      pc_q          <= RESET_PC;
      pc_inflight_q <= RESET_PC;
    end else begin
      if (i_pc_selE)     pc_q <= i_pc_targetE;
      else if (accepted) pc_q <= pc_q + 32'd4;

      if (accepted) pc_inflight_q <= pc_q;

      case (state_q)
        F_REQ:   if (accepted) state_q <= i_pc_selE ? F_DROP : F_WAIT;
        F_WAIT:  begin
          if (i_imem_rvalid)  state_q <= F_REQ;
          else if (i_pc_selE) state_q <= F_DROP;
        end
        F_DROP:  if (i_imem_rvalid) state_q <= F_REQ;
        default: state_q <= F_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ifid_q <= {NOP_INSN, 32'd0, 32'd0, 1'b0};
    end else if (i_flushD) begin
      ifid_q <= {NOP_INSN, 32'd0, 32'd0, 1'b0};
    end else if (!i_stallD) begin
      if (skid_full && !i_pc_selE) begin
        ifid_q <= skid_data;
      end else if (deliver) begin
        ifid_q <= resp;
      end else begin
        ifid_q.insn  <= NOP_INSN;
        ifid_q.valid <= 1'b0;
      end
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = pc_q;
  assign o_InstrD    = ifid_q.insn;
  assign o_PCD       = ifid_q.pc;
  assign o_PCPlus4D  = ifid_q.pc_plus4;
  assign o_validD    = ifid_q.valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle -- scoreboard bench for fetch_cycle with a behavioural imem.
// Revision: 1.0
`default_nettype none

module tb_fetch_cycle;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        r_clk = 1'b0;
  logic        r_rst_n;
  logic        r_stallF, r_stallD, r_flushD, r_pc_selE;
  logic [31:0] r_target;
  logic        r_gnt_en;
  int          r_lat;

  logic        w_req, w_gnt, w_rvalid, w_validD;
  logic [31:0] w_addr, w_rdata, w_InstrD, w_PCD, w_PCPlus4D;

  logic        r_pend, r_killed, r_stall_seen;
  logic [31:0] r_paddr;
  logic [3:0]  r_cnt;

  exp_t sb_q[$];
  exp_t r_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 r_clk = ~r_clk;

  fetch_cycle dut (
    .i_clk         (r_clk),
    .i_rst_n       (r_rst_n),
    .i_stallF      (r_stallF),
    .i_stallD      (r_stallD),
    .i_flushD      (r_flushD),
    .i_pc_selE     (r_pc_selE),
    .i_pc_targetE  (r_target),
    .o_imem_req    (w_req),
    .o_imem_addr   (w_addr),
    .i_imem_gnt    (w_gnt),
    .i_imem_rvalid (w_rvalid),
    .i_imem_rdata  (w_rdata),
    .o_InstrD      (w_InstrD),
    .o_PCD         (w_PCD),
    .o_PCPlus4D    (w_PCPlus4D),
    .o_validD      (w_validD)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0)   return 32'h0050_0093;
    if (a == 32'h104) return 32'h00A0_0113;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Imem: grant whenever enabled, respond r_lat cycles after grant.
  assign w_gnt    = w_req & r_gnt_en;
  assign w_rvalid = r_pend && (r_cnt == 4'd0);
  assign w_rdata  = w_rvalid ? memf(r_paddr) : 32'hxxxx_xxxx;

  // A fetch survives only if no redirect is seen from its grant through its response.
  always @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_pend   <= 1'b0;
      r_cnt    <= 4'd0;
      r_killed <= 1'b0;
      r_paddr  <= 32'd0;
    end else if (w_gnt) begin
      r_pend   <= 1'b1;
      r_paddr  <= w_addr;
      r_cnt    <= 4'(r_lat - 1);
      r_killed <= r_pc_selE;
    end else if (r_pend) begin
      if (w_rvalid) begin
        r_pend <= 1'b0;
        if (!(r_killed | r_pc_selE))
          sb_q.push_back({memf(r_paddr), r_paddr, r_paddr + 32'd4});
      end else begin
        if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        if (r_pc_selE) r_killed <= 1'b1;
      end
    end
  end

  always @(posedge r_clk) r_stall_seen <= r_stallD;

  always @(negedge r_clk) begin
    if (r_rst_n && !r_stall_seen && w_validD) begin
      check("sb_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        r_exp = sb_q.pop_front();
        check("sb_insn", w_InstrD, r_exp.insn);
        check("sb_pc", w_PCD, r_exp.pc);
        check("sb_pc4", w_PCPlus4D, r_exp.pc4);
      end
    end
  end

  task automatic step();
    @(posedge r_clk);
    #2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_instr"}, w_InstrD, 32'h0000_0013);
    check({tag, "_pcd"}, w_PCD, 32'd0);
    check({tag, "_pc4"}, w_PCPlus4D, 32'd0);
    check({tag, "_valid"}, 32'(w_validD), 32'd0);
    check({tag, "_req"}, 32'(w_req), 32'd0);
    check({tag, "_addr"}, w_addr, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r_rst_n = 1'b0; r_stallF = 1'b0; r_stallD = 1'b0; r_flushD = 1'b0;
    r_pc_selE = 1'b0; r_target = 32'd0; r_gnt_en = 1'b1; r_lat = 1;
    step(); step();
    check_reset("rst");

    r_rst_n = 1'b1;
    #1;
    check("first_req", 32'(w_req), 32'd1);
    check("first_addr", w_addr, 32'd0);
    step();
    check("wait_no_req", 32'(w_req), 32'd0);
    step();
    check("d0_instr", w_InstrD, 32'h0050_0093);
    check("d0_pcd", w_PCD, 32'd0);
    check("d0_pc4", w_PCPlus4D, 32'd4);
    check("d0_valid", 32'(w_validD), 32'd1);
    check("next_addr4", w_addr, 32'd4);

    // Redirect while waiting on the response for 8.
    step(); step(); step();
    r_pc_selE = 1'b1; r_target = 32'h100;
    step();
    r_pc_selE = 1'b0;
    check("redir_valid", 32'(w_validD), 32'd0);
    check("redir_req", 32'(w_req), 32'd1);
    check("redir_addr", w_addr, 32'h100);

    // Decode stall while the response for 0x104 arrives.
    step(); step(); step();
    r_stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", 32'(w_req), 32'd0);
      check("stall_instr", w_InstrD, 32'h0000_0013);
      check("stall_pcd", w_PCD, 32'h100);
    end
    r_stallD = 1'b0;
    step();
    check("skid_instr", w_InstrD, 32'h00A0_0113);
    check("skid_pcd", w_PCD, 32'h104);
    check("skid_pc4", w_PCPlus4D, 32'h108);
    check("skid_valid", 32'(w_validD), 32'd1);

    // Flush pulse in a cycle without a response.
    step(); step();
    r_flushD = 1'b1;
    step();
    r_flushD = 1'b0;
    check("flush_instr", w_InstrD, 32'h0000_0013);
    check("flush_valid", 32'(w_validD), 32'd0);
    check("flush_pcd", w_PCD, 32'd0);
    step();
    check("flush_1cyc", 32'(w_validD), 32'd1);
    check("flush_next_pc", w_PCD, 32'h10C);

    // Fetch stall.
    r_stallF = 1'b1;
    #1;
    check("stallF_req", 32'(w_req), 32'd0);
    check("stallF_addr", w_addr, 32'h110);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stallF_req", 32'(w_req), 32'd0);
      check("stallF_addr", w_addr, 32'h110);
    end
    r_stallF = 1'b0;
    #1;
    check("stallF_resume", 32'(w_req), 32'd1);

    // Redirect coinciding with a grant, then PC wrap.
    step(); step();
    r_pc_selE = 1'b1; r_target = 32'hFFFF_FFFC;
    step();
    r_pc_selE = 1'b0;
    check("drop_req", 32'(w_req), 32'd0);
    check("drop_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc0", w_addr, 32'd0);
    step();
    check("wrap_pcd", w_PCD, 32'hFFFF_FFFC);
    check("wrap_pc4", w_PCPlus4D, 32'd0);
    check("wrap_next", w_addr, 32'd0);
    r_lat = 3;

    // Asynchronous reset in the middle of an outstanding fetch.
    step();
    #1 r_rst_n = 1'b0;
    #1 check_reset("async");
    step(); step();
    r_rst_n = 1'b1; r_lat = 1;
    for (int i = 0; i < 8; i++) step();
    r_gnt_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Sits directly upstream of decode and produces InstrD/PCD/PCPlus4D through the IF/ID pipeline register.
- Owns the PC and a single-outstanding req/gnt/rvalid instruction-memory handshake.
- Honours hazard-unit stall/flush and execute-stage branch/jump redirects, and discards responses belonging to killed fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSN, 32'h0000_0013, encoding inserted into IF/ID on bubble/flush (addi x0,x0,0)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_stallF  in  1  hazard unit: hold PC, issue no new request
i_stallD  in  1  hazard unit: hold IF/ID register
i_flushD  in  1  hazard unit: load bubble into IF/ID
i_pc_selE  in  1  execute: branch taken / jump, redirect PC
i_pc_targetE  in  32  execute: redirect target
o_imem_req  out  1  fetch request valid
o_imem_addr  out  32  fetch address (= PC)
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  response valid; at least 1 cycle after gnt
i_imem_rdata  in  32  instruction word
o_InstrD  out  32  IF/ID instruction
o_PCD  out  32  IF/ID PC
o_PCPlus4D  out  32  IF/ID PC+4
o_validD  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, while i_rst_n=0):
  - PC=RESET_PC, state=F_REQ, skid buffer empty.
  - o_InstrD=NOP_INSN, o_PCD=0, o_PCPlus4D=0, o_validD=0.
  - o_imem_req forced 0.
  - Reset mid-transaction abandons any outstanding request; the memory side is reset by the same signal.
- o_imem_addr = PC at all times.
- o_imem_req = (state==F_REQ) & ~i_stallF & ~skid_full & i_rst_n.
- FSM states: F_REQ, F_WAIT, F_DROP. At most one request outstanding.
- F_REQ:
  - req&gnt & ~i_pc_selE: pc_inflight<=PC, PC<=PC+4, go F_WAIT.
  - req&gnt & i_pc_selE: PC<=i_pc_targetE, go F_DROP (the granted fetch is stale).
  - No gnt & i_pc_selE: PC<=i_pc_targetE, stay F_REQ.
- F_WAIT:
  - rvalid & i_pc_selE: discard data, PC<=target, go F_REQ.
  - rvalid, no redirect: deliver {rdata, pc_inflight, pc_inflight+4} and go F_REQ. Back-to-back issue in the same cycle is not allowed; throughput is at best 1 insn / 2 cycles.
  - No rvalid & i_pc_selE: PC<=target, go F_DROP.
- F_DROP: on rvalid, discard data and go F_REQ. A redirect here updates PC only.
- Redirect (i_pc_selE) overrides i_stallF for the PC update and empties the skid buffer.
- Delivery and IF/ID update, in priority order:
  1. i_flushD: IF/ID <= {NOP_INSN, 0, 0}, o_validD=0. If a response is delivered in the same cycle, it goes to the skid buffer, unless a redirect also occurs (then it is dropped).
  2. i_stallD: IF/ID holds. A delivered response goes to the skid buffer (1 entry).
  3. Skid full: IF/ID <= skid, skid empties. A simultaneous delivery cannot occur because requests are suppressed while the skid is full.
  4. Delivered response: IF/ID <= response, o_validD=1.
  5. Otherwise: IF/ID <= bubble (NOP_INSN, o_validD=0; PCD/PCPlus4D hold).
- Widths: PC arithmetic is modulo 2^32; PC+4 wraps 32'hFFFF_FFFC -> 0. PC[1:0] is not checked.
- Latency: gnt at cycle t, rvalid at t+k (k≥1) -> IF/ID valid at t+k+1 when not stalled.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {F_REQ, F_WAIT, F_DROP}.
  - localparam NOP_INSN.
  - typedef struct ifid_t {insn, pc, pc_plus4, valid}.
- One sub-module, fetch_skid_buf: 1-entry buffer of ifid_t with load/pop/clear and a full flag.

Test Plan:
- Reset release, memory with gnt immediate, rvalid 1 cycle later, rdata=32'h0050_0093 -> request addr 0; IF/ID = {00500093, PCD 0, PCPlus4D 4, valid 1}; next request addr 4.
- i_pc_selE=1, target 32'h100, asserted while in F_WAIT for addr 8 -> response for 8 discarded, o_validD never 1 for PC 8; next request addr 32'h100.
- i_stallD held 3 cycles while rdata 32'h00A0_0113 arrives -> skid full, o_imem_req=0, IF/ID unchanged; IF/ID loads 00A00113 the cycle after stallD drops.
- i_flushD pulse with no response -> o_InstrD=32'h13, o_validD=0 for exactly one cycle.
- i_stallF=1 for 4 cycles in F_REQ -> o_imem_req=0, o_imem_addr constant; resumes when stallF drops.
- Redirect to 32'hFFFF_FFFC -> fetch addr FFFFFFFC, PCPlus4D=0, next request addr 0; async reset asserted mid-F_WAIT -> all outputs return to reset values immediately.
